// File: rtl/note_scheduler.sv
// Note scheduler: steps through a song pattern at a fixed step rate and
// issues spawn requests to two lanes, flagging notes dropped on a busy lane.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start; step holds its last value
// S_WAIT    | waiting for the tick that opens the next pattern step
// S_FETCH   | pattern word for the current step is captured
// S_ISSUE   | requests raised for the noted lanes, step advanced or song ends
// S_END     | song finished; waiting for both lanes to drain before done
module note_scheduler #(
    parameter int TICK_DIV = 1000000,
    parameter int STEPS    = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic [1:0]        pat_data,
    output logic              spawn1_req,
    output logic              spawn2_req,
    input  logic              spawn1_ack,
    input  logic              spawn2_ack,
    output logic [ADDR_W-1:0] step,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int                CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] STEP_LAST = ADDR_W'(STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_ISSUE,
        S_END
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_tick_cnt;
    logic [ADDR_W-1:0]   r_step;
    logic [1:0]          r_pat;
    logic                r_req1;
    logic                r_req2;
    logic                r_overrun;

    logic                w_start_song;
    logic                w_tick;
    logic                w_issue;
    logic                w_drop1;
    logic                w_drop2;

    assign w_start_song = (r_state == S_IDLE) && start;
    // The tick counter keeps running through FETCH/ISSUE so the step period
    // never stretches; TICK_DIV >= 3 guarantees we are back in S_WAIT in time.
    assign w_tick       = (r_state != S_IDLE) && !pause && (r_tick_cnt == TICK_LAST);
    assign w_issue      = (r_state == S_ISSUE);
    // A note on a lane whose request is still outstanding and not being
    // accepted this cycle is lost; the pending request covers it.
    assign w_drop1      = w_issue && r_pat[0] && r_req1 && !spawn1_ack;
    assign w_drop2      = w_issue && r_pat[1] && r_req2 && !spawn2_ack;

    assign pat_addr   = r_step;
    assign step       = r_step;
    assign spawn1_req = r_req1;
    assign spawn2_req = r_req2;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_END) && !r_req1 && !r_req2;
    assign overrun    = r_overrun;

    // Next-state decode for the song sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_WAIT;
            S_WAIT:  if (w_tick) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = (r_step == STEP_LAST) ? S_END : S_WAIT;
            S_END:   if (!r_req1 && !r_req2) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Free-running step-rate counter, frozen by pause, restarted by start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_start_song) begin
            r_tick_cnt <= '0;
        end else if ((r_state != S_IDLE) && !pause) begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + CNT_W'(1);
        end
    end

    // Step index: cleared on start, advanced on leaving ISSUE, held at the end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step <= '0;
        end else if (w_start_song) begin
            r_step <= '0;
        end else if (w_issue && (r_step != STEP_LAST)) begin
            r_step <= r_step + ADDR_W'(1);
        end
    end

    // Capture the pattern word addressed during the wait phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  r_pat <= '0;
        else if (r_state == S_FETCH) r_pat <= pat_data;
    end

    // Lane request handshakes: a new note wins over a same-cycle acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req1 <= 1'b0;
            r_req2 <= 1'b0;
        end else begin
            if (w_issue && r_pat[0])      r_req1 <= 1'b1;
            else if (r_req1 && spawn1_ack) r_req1 <= 1'b0;
            if (w_issue && r_pat[1])      r_req2 <= 1'b1;
            else if (r_req2 && spawn2_ack) r_req2 <= 1'b0;
        end
    end

    // Sticky drop flag, cleared only by a new song.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  r_overrun <= 1'b0;
        else if (w_start_song)       r_overrun <= 1'b0;
        else if (w_drop1 || w_drop2) r_overrun <= 1'b1;
    end

endmodule
